// File: rtl/pc_sequencer.sv
// PC / instruction-fetch stage: fetch over req/ack, hand to decode over valid/ready.
// Optional return stack enabled by defining PC_RETURN_STACK_EN.
module pc_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_sel,
  input  logic               jump_taken,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output logic               halted
`ifdef PC_RETURN_STACK_EN
  ,
  input  logic               call,
  input  logic               ret,
  output logic               stack_err
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc    = pc + PC_W'(1);
  assign imem_addr = pc;

`ifdef PC_RETURN_STACK_EN
  logic [PC_W-1:0] stk [4];
  logic [2:0]      depth;
  logic [1:0]      top_idx;

  assign top_idx = depth[1:0] - 2'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef PC_RETURN_STACK_EN
      depth       <= '0;
      stack_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_FETCH: begin
          state    <= S_WAIT;
          imem_req <= 1'b1;
        end
        S_WAIT: begin
          if (imem_ack) begin
            instr       <= imem_data;
            state       <= S_HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_FETCH;
            // halt outranks every PC update, including stack ops
            if (halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
`ifdef PC_RETURN_STACK_EN
            else if (call && ret) begin
              stack_err <= 1'b1;
              pc        <= pc_inc;
            end else if (call) begin
              if (depth == 3'd4) begin
                stack_err <= 1'b1;
                pc        <= pc_inc;
              end else begin
                stk[depth[1:0]] <= pc_inc;
                depth           <= depth + 3'd1;
                pc              <= jump_target;
              end
            end else if (ret) begin
              if (depth == 3'd0) begin
                stack_err <= 1'b1;
                pc        <= pc_inc;
              end else begin
                pc    <= stk[top_idx];
                depth <= depth - 3'd1;
              end
            end
`endif
            else if (jump_sel && jump_taken) begin
              pc <= jump_target;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, corner sequences,
// and randomized instructions against a next-PC reference model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       jump_sel = 1'b0;
  logic       jump_taken = 1'b0;
  logic [7:0] jump_target = '0;
  logic       halt = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = '0;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] pc;
  logic       halted;
`ifdef PC_RETURN_STACK_EN
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic       stack_err;
  logic       r_call = 1'b0;
  logic       r_ret = 1'b0;
`endif

  int npass = 0;
  int ntot  = 0;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .jump_sel    (jump_sel),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .halted      (halted)
`ifdef PC_RETURN_STACK_EN
    ,
    .call        (call),
    .ret         (ret),
    .stack_err   (stack_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d;
    logic       sel;
    logic       tk;
    logic [7:0] tgt;
    logic [7:0] exp_next;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] p,
      input logic h, input logic s, input logic t, input logic [7:0] g);
    if (h) return p;
    if (s && t) return g;
    return 8'((p + 9'd1) % 9'd256);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    jump_sel = 1'b0;
    jump_taken = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_instr", instr, 8'h00);
`ifdef PC_RETURN_STACK_EN
    chk("rst_serr", stack_err, 1'b0);
`endif
  endtask

  // Starts and ends at a negedge while the DUT is in its fetch cycle.
  task automatic run_instr(input logic [7:0] d, input logic sel,
      input logic tk, input logic [7:0] tgt, input logic hlt,
      input int dly, input int stall,
      input logic [7:0] exp_pc, input logic [7:0] exp_next);
    chk("fetch_req", imem_req, 1'b0);
    chk("fetch_valid", instr_valid, 1'b0);
    chk("fetch_pc", pc, exp_pc);
    imem_ack = 1'b1;
    imem_data = 8'hEE;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < dly; i++) begin
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", instr_valid, 1'b0);
      @(negedge clk);
    end
    chk("wait_req", imem_req, 1'b1);
    chk("wait_addr", imem_addr, exp_pc);
    imem_ack = 1'b1;
    imem_data = d;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", instr, d);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_pc", pc, exp_pc);
      instr_ready = 1'b0;
      imem_ack = 1'b1;
      imem_data = ~d;
      jump_sel = 1'b1;
      jump_taken = 1'b1;
      jump_target = ~exp_pc;
      halt = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("hold_valid", instr_valid, 1'b1);
    chk("hold_instr", instr, d);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_pc", pc, exp_pc);
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    jump_sel = sel;
    jump_taken = tk;
    jump_target = tgt;
    halt = hlt;
`ifdef PC_RETURN_STACK_EN
    call = r_call;
    ret = r_ret;
`endif
    @(negedge clk);
    instr_ready = 1'b0;
    jump_sel = 1'b0;
    jump_taken = 1'b0;
    halt = 1'b0;
`ifdef PC_RETURN_STACK_EN
    call = 1'b0;
    ret = 1'b0;
    r_call = 1'b0;
    r_ret = 1'b0;
`endif
    chk("retire_valid", instr_valid, 1'b0);
    chk("retire_halted", halted, hlt);
    chk("retire_pc", pc, exp_next);
  endtask

  initial begin
    logic [7:0] mpc;
    logic [7:0] nxt;
    logic [7:0] rd;
    logic       rs;
    logic       rt;
    logic [7:0] rg;

    tbl[0] = '{8'h3C, 1'b0, 1'b0, 8'h00, 8'h01};
    tbl[1] = '{8'h11, 1'b1, 1'b1, 8'h10, 8'h10};
    tbl[2] = '{8'h12, 1'b1, 1'b1, 8'hA5, 8'hA5};
    tbl[3] = '{8'h13, 1'b1, 1'b1, 8'h10, 8'h10};
    tbl[4] = '{8'h14, 1'b1, 1'b0, 8'hA5, 8'h11};
    tbl[5] = '{8'h15, 1'b0, 1'b1, 8'h33, 8'h12};
    tbl[6] = '{8'h16, 1'b1, 1'b1, 8'hFF, 8'hFF};
    tbl[7] = '{8'h17, 1'b0, 1'b0, 8'h42, 8'h00};

    do_reset();
    mpc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].d, tbl[i].sel, tbl[i].tk, tbl[i].tgt, 1'b0,
                (i == 0) ? 0 : i % 3, 0, mpc, tbl[i].exp_next);
      mpc = tbl[i].exp_next;
    end

    run_instr(8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 2, 5, 8'h00, 8'h01);

    // halt beats a simultaneous taken jump; halted state is terminal
    do_reset();
    run_instr(8'h01, 1'b1, 1'b1, 8'h20, 1'b0, 0, 0, 8'h00, 8'h20);
    run_instr(8'h02, 1'b1, 1'b1, 8'hA5, 1'b1, 1, 1, 8'h20, 8'h20);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      instr_ready = 1'b1;
      jump_sel = 1'b1;
      jump_taken = 1'b1;
      @(negedge clk);
      chk("halt_halted", halted, 1'b1);
      chk("halt_req", imem_req, 1'b0);
      chk("halt_pc", pc, 8'h20);
      chk("halt_instr", instr, 8'h02);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    jump_sel = 1'b0;
    jump_taken = 1'b0;

    // reset in the middle of a memory wait drops the pending ack
    do_reset();
    run_instr(8'h03, 1'b1, 1'b1, 8'h5A, 1'b0, 0, 0, 8'h00, 8'h5A);
    @(negedge clk);
    chk("midrst_req_pre", imem_req, 1'b1);
    chk("midrst_addr_pre", imem_addr, 8'h5A);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_data = 8'h99;
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b0;
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_valid", instr_valid, 1'b0);
    chk("midrst_instr", instr, 8'h00);
    @(negedge clk);
    chk("midrst_req2", imem_req, 1'b1);
    chk("midrst_addr2", imem_addr, 8'h00);

`ifdef PC_RETURN_STACK_EN
    do_reset();
    run_instr(8'h01, 1'b1, 1'b1, 8'h05, 1'b0, 0, 0, 8'h00, 8'h05);
    r_call = 1'b1;
    run_instr(8'h02, 1'b0, 1'b0, 8'h40, 1'b0, 0, 0, 8'h05, 8'h40);
    r_ret = 1'b1;
    run_instr(8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 8'h40, 8'h06);
    chk("stk_err0", stack_err, 1'b0);
    r_call = 1'b1;
    run_instr(8'h04, 1'b0, 1'b0, 8'h40, 1'b0, 0, 0, 8'h06, 8'h40);
    for (int i = 0; i < 3; i++) begin
      r_call = 1'b1;
      run_instr(8'h05, 1'b0, 1'b0, 8'h40, 1'b0, 0, 0, 8'h40, 8'h40);
    end
    chk("stk_err_full_pre", stack_err, 1'b0);
    r_call = 1'b1;
    run_instr(8'h06, 1'b0, 1'b0, 8'h40, 1'b0, 0, 0, 8'h40, 8'h41);
    chk("stk_err_full", stack_err, 1'b1);
    r_ret = 1'b1;
    run_instr(8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 8'h41, 8'h41);
    chk("stk_err_sticky", stack_err, 1'b1);
    do_reset();
`endif

    // randomized instruction stream against the next-PC model
    do_reset();
    mpc = 8'h00;
    for (int n = 0; n < 60; n++) begin
      rd = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      rg = 8'($urandom);
      nxt = model_next(mpc, 1'b0, rs, rt, rg);
      run_instr(rd, rs, rt, rg, 1'b0, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), mpc, nxt);
      mpc = nxt;
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and instruction-fetch stage directly downstream of the bus arbiter.
- Consumes the conditional jump target the arbiter places on the bus, together with its select strobe and condition result.
- Sequences 8-bit instruction fetches from instruction memory over a req/ack handshake and presents each instruction to decode over a valid/ready handshake.
- On each retired instruction, the PC either increments or loads the jump target.

Parameters:
- PC_W, 8, program counter and address width (matches the 8-bit bus).
- INSTR_W, 8, instruction word width.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- jump_sel  in  1  arbiter select strobe; a jump instruction is in decode.
- jump_taken  in  1  condition met; high exactly when the arbiter drives reg_0 onto the bus.
- jump_target  in  PC_W  arbiter_out bus value; used only when jump_sel & jump_taken.
- halt  in  1  decode reports a halt instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  memory returns data this cycle.
- imem_data  in  INSTR_W  fetched instruction.
- instr  out  INSTR_W  registered instruction to decode.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  decode accepts instr.
- pc  out  PC_W  current program counter.
- halted  out  1  sequencer is stopped.

Behaviour:
- Reset (rst=1 at a rising clk):
  - pc=RESET_PC, state=S_FETCH, instr=0.
  - imem_req=0, instr_valid=0, halted=0.
  - rst overrides every state, including mid-handshake; an outstanding ack is dropped.
- States: S_FETCH, S_WAIT, S_HOLD, S_HALT, 2-bit encoding 0..3.
- Outputs are Moore and decoded from state:
  - imem_req = (state==S_WAIT).
  - instr_valid = (state==S_HOLD).
  - halted = (state==S_HALT).
  - imem_addr = pc at all times.
- S_FETCH:
  - Lasts exactly one cycle, then goes to S_WAIT.
- S_WAIT:
  - imem_req held high until imem_ack.
  - On imem_ack: instr<=imem_data, go to S_HOLD.
  - imem_ack outside S_WAIT is ignored.
  - No timeout; waits indefinitely.
- S_HOLD:
  - instr stable while instr_valid=1 and instr_ready=0.
  - On instr_ready=1 the instruction retires that cycle.
  - If halt=1: go to S_HALT; pc unchanged.
  - Else if jump_sel & jump_taken: pc<=jump_target, go to S_FETCH.
  - Else: pc<=pc+1 modulo 2^PC_W (8'hFF wraps to 8'h00), go to S_FETCH.
  - halt has priority over a simultaneous taken jump.
  - jump_sel, jump_taken and halt are sampled only in S_HOLD with instr_ready=1 and are ignored otherwise.
  - jump_sel=1 with jump_taken=0 gives pc+1.
- S_HALT:
  - Terminal; pc and instr frozen.
  - Exited only by rst.
- Throughput: minimum 3 cycles per instruction (FETCH, WAIT with same-cycle ack, HOLD with ready=1).
- First imem_req rises in the 2nd cycle after rst deasserts.
- All state updates occur on the rising clk edge; no combinational path from any input to any output.

Optional Feature:
- Macro: PC_RETURN_STACK_EN.
- When defined:
  - Adds inputs call (1) and ret (1), and output stack_err (1).
  - Adds a 4-entry PC_W-bit return stack with a 3-bit depth counter.
  - Evaluated in S_HOLD on instr_ready, below halt and above jump in priority.
  - call: push pc+1, pc<=jump_target.
  - ret: pc<=top, pop.
  - call and ret together: stack_err set, treated as plain pc+1.
  - Push when full, or pop when empty: stack_err is set and sticky until rst; pc<=pc+1; stack unchanged.
  - Reset clears the depth counter and stack_err.
- When undefined:
  - Ports and stack logic are absent.
  - Behaviour is exactly as described above.

Test Plan:
- Reset then ack in the first S_WAIT cycle with imem_data=8'h3C, ready=1 -> imem_addr=00; instr=3C with instr_valid for 1 cycle; next imem_addr=01; 3-cycle cadence.
- Retire at pc=8'h10 with jump_sel=1, jump_taken=1, jump_target=8'hA5 -> next imem_addr=A5; repeat with jump_taken=0 -> 11.
- pc=8'hFF, non-jump retire -> pc=8'h00.
- instr_ready low for 5 cycles with instr=8'h77 -> instr_valid and instr stay 77, pc unchanged; ack pulses during the stall are ignored.
- halt=1 together with a taken jump at pc=8'h20 -> halted=1, pc stays 20, imem_req stays 0 until rst; rst asserted mid-S_WAIT -> pc=00, imem_req=0 next cycle.
- PC_RETURN_STACK_EN: call at pc=8'h05 to 8'h40, then ret -> fetch 40, then 06; five calls -> stack_err=1 on the 5th, pc=pc+1.
